// File: rtl/sd_pixel_packer.sv
// Packs the SD reader byte stream into BYTES_PER_PIXEL-wide pixels with frame addresses, via a 2-entry valid/ready buffer.
// Define PACKER_HDR_SKIP_EN to compile in the per-frame HDR_BYTES header skip.
module sd_pixel_packer #(
    parameter int BYTES_PER_PIXEL = 3,
    parameter int FRAME_W         = 640,
    parameter int FRAME_H         = 480,
    parameter int ADDR_W          = 19,
    parameter int LOOP            = 1,
    parameter int HDR_BYTES       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_tvalid,
    input  logic [7:0]                   i_tdata,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    output logic [8*BYTES_PER_PIXEL-1:0] o_tdata,
    output logic [ADDR_W-1:0]            o_taddr,
    output logic                         frame_done,
    output logic [7:0]                   frame_cnt,
    output logic                         overflow
);

    localparam int PIX_W = 8*BYTES_PER_PIXEL;
    localparam int ASM_W = (BYTES_PER_PIXEL > 1) ? 8*(BYTES_PER_PIXEL-1) : 8;
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_PIXEL-1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W*FRAME_H-1);

    typedef enum logic [1:0] {S_HDR, S_PIX, S_DONE} state_t;

`ifdef PACKER_HDR_SKIP_EN
    localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES+1) : 1;
    localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_BYTES);
    localparam state_t FRAME_START = (HDR_BYTES > 0) ? S_HDR : S_PIX;
    logic [HDR_W-1:0] hdr_cnt_q, hdr_cnt_d;
`else
    localparam state_t FRAME_START = S_PIX;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic [PIX_W-1:0]  fifo_data_q [2];
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic              rd_q, wr_q;
    logic [1:0]        cnt_q;

    logic [PIX_W-1:0]  pix_w;
    logic              pix_done, push, pop;

    generate
        if (BYTES_PER_PIXEL == 1) begin : g_pix1
            assign pix_w = i_tdata;
        end else begin : g_pixn
            assign pix_w = {asm_q, i_tdata};
        end
    endgenerate

    assign pop      = (cnt_q != 2'd0) & o_tready;
    assign pix_done = (state_q == S_PIX) & i_tvalid & (byte_cnt_q == LAST_BYTE);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push     = pix_done & ((cnt_q != 2'd2) | pop);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        pix_addr_d   = pix_addr_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (pix_done & ~push);
`ifdef PACKER_HDR_SKIP_EN
        hdr_cnt_d    = hdr_cnt_q;
`endif
        case (state_q)
            S_HDR: begin
`ifdef PACKER_HDR_SKIP_EN
                if (i_tvalid) begin
                    if (hdr_cnt_q + 1'b1 == HDR_LAST) begin
                        hdr_cnt_d = '0;
                        state_d   = S_PIX;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end
                end
`else
                state_d = S_PIX;
`endif
            end
            S_PIX: begin
                if (i_tvalid) begin
                    asm_d = pix_w[ASM_W-1:0];
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        // Geometry advances even when the pixel itself is dropped.
                        if (pix_addr_q == LAST_ADDR) begin
                            pix_addr_d   = '0;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            state_d      = (LOOP != 0) ? FRAME_START : S_DONE;
                        end else begin
                            pix_addr_d = pix_addr_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_DONE: ;
            default: state_d = FRAME_START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FRAME_START;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            pix_addr_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef PACKER_HDR_SKIP_EN
            hdr_cnt_q    <= '0;
`endif
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            pix_addr_q   <= pix_addr_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
`ifdef PACKER_HDR_SKIP_EN
            hdr_cnt_q    <= hdr_cnt_d;
`endif
            if (push) begin
                fifo_data_q[wr_q] <= pix_w;
                fifo_addr_q[wr_q] <= pix_addr_q;
                wr_q              <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign o_tvalid   = (cnt_q != 2'd0);
    assign o_tdata    = fifo_data_q[rd_q];
    assign o_taddr    = fifo_addr_q[rd_q];
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sd_pixel_packer.sv
// Directed bench for sd_pixel_packer on a 4x2 frame of 3-byte pixels; header checks run when PACKER_HDR_SKIP_EN is defined.
module tb_sd_pixel_packer;

    localparam int BPP = 3;
    localparam int AW  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tvalid;
    logic [7:0] i_tdata;
    logic       o_tready;

    logic        l_valid, o_valid, h_valid, m_valid;
    logic [23:0] l_data, o_data, h_data, m_data;
    logic [2:0]  l_addr, o_addr, h_addr, m_addr;
    logic        l_fd, o_fd, h_fd, m_fd;
    logic [7:0]  l_fcnt, o_fcnt, h_fcnt, m_fcnt;
    logic        l_ovf, o_ovf, h_ovf, m_ovf;
    int          sel = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sd_pixel_packer #(.BYTES_PER_PIXEL(BPP), .FRAME_W(4), .FRAME_H(2), .ADDR_W(AW),
                      .LOOP(1), .HDR_BYTES(0)) u_loop (
        .clk(clk), .reset(reset), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
        .o_tvalid(l_valid), .o_tready(o_tready), .o_tdata(l_data), .o_taddr(l_addr),
        .frame_done(l_fd), .frame_cnt(l_fcnt), .overflow(l_ovf));

    sd_pixel_packer #(.BYTES_PER_PIXEL(BPP), .FRAME_W(4), .FRAME_H(2), .ADDR_W(AW),
                      .LOOP(0), .HDR_BYTES(0)) u_once (
        .clk(clk), .reset(reset), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
        .o_tvalid(o_valid), .o_tready(o_tready), .o_tdata(o_data), .o_taddr(o_addr),
        .frame_done(o_fd), .frame_cnt(o_fcnt), .overflow(o_ovf));

`ifdef PACKER_HDR_SKIP_EN
    sd_pixel_packer #(.BYTES_PER_PIXEL(BPP), .FRAME_W(4), .FRAME_H(2), .ADDR_W(AW),
                      .LOOP(1), .HDR_BYTES(2)) u_hdr (
        .clk(clk), .reset(reset), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
        .o_tvalid(h_valid), .o_tready(o_tready), .o_tdata(h_data), .o_taddr(h_addr),
        .frame_done(h_fd), .frame_cnt(h_fcnt), .overflow(h_ovf));
`else
    assign {h_valid, h_data, h_addr, h_fd, h_fcnt, h_ovf} = '0;
`endif

    always_comb begin
        case (sel)
            1:       {m_valid, m_data, m_addr, m_fd, m_fcnt, m_ovf} = {o_valid, o_data, o_addr, o_fd, o_fcnt, o_ovf};
            2:       {m_valid, m_data, m_addr, m_fd, m_fcnt, m_ovf} = {h_valid, h_data, h_addr, h_fd, h_fcnt, h_ovf};
            default: {m_valid, m_data, m_addr, m_fd, m_fcnt, m_ovf} = {l_valid, l_data, l_addr, l_fd, l_fcnt, l_ovf};
        endcase
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ev;
        logic [23:0] ed;
        logic [2:0]  ea;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        i_tvalid = v;
        i_tdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        i_tvalid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    // Byte k carries value k, so pixel p is {3p, 3p+1, 3p+2}.
    task automatic run_stream(input string tag, input int nbytes, input int npix, output int fd_count);
        int p;
        fd_count = 0;
        for (int k = 0; k < nbytes; k++) begin
            step(1'b1, 8'(k));
            p = k / 3;
            if ((k % 3 == 2) && (p < npix)) begin
                chk({tag, "_valid"}, m_valid, 1);
                chk({tag, "_data"}, m_data, {8'(3*p), 8'(3*p+1), 8'(3*p+2)});
                chk({tag, "_addr"}, m_addr, 32'(p % 8));
                chk({tag, "_fd"}, m_fd, (p % 8 == 7) ? 1 : 0);
            end else begin
                chk({tag, "_idle_valid"}, m_valid, 0);
                chk({tag, "_idle_fd"}, m_fd, 0);
            end
            if (m_fd) fd_count++;
        end
        step(1'b0, 8'h00);
        chk({tag, "_tail_valid"}, m_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fdc;

        tbl[0] = '{1'b1, 8'h11, 1'b0, 24'h0, 3'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 24'h0, 3'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 24'h112233, 3'd0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 24'h0, 3'd0};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 24'h0, 3'd0};
        tbl[5] = '{1'b1, 8'h66, 1'b1, 24'h445566, 3'd1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 24'h0, 3'd0};

        reset    = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = 8'h00;
        o_tready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", l_valid, 0);
        chk("rst_data", l_data, 0);
        chk("rst_addr", l_addr, 0);
        chk("rst_fd", l_fd, 0);
        chk("rst_fcnt", l_fcnt, 0);
        chk("rst_ovf", l_ovf, 0);

        // Basic packing, one vector per clock.
        sel = 0;
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("basic%0d_valid", i), m_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("basic%0d_data", i), m_data, tbl[i].ed);
                chk($sformatf("basic%0d_addr", i), m_addr, tbl[i].ea);
            end
        end

        // Frame wrap with LOOP=1.
        do_reset();
        sel = 0;
        run_stream("wrap", 27, 9, fdc);
        chk("wrap_fd_pulses", fdc, 1);
        chk("wrap_fcnt", m_fcnt, 1);

        // One-shot with LOOP=0: bytes past the first frame are ignored.
        do_reset();
        sel = 1;
        run_stream("once", 30, 8, fdc);
        chk("once_fd_pulses", fdc, 1);
        chk("once_fcnt", m_fcnt, 1);
        step(1'b1, 8'hA0);
        step(1'b1, 8'hA1);
        step(1'b1, 8'hA2);
        chk("once_done_valid", m_valid, 0);

        // Full buffer with a pop in the same cycle as the push.
        do_reset();
        sel = 0;
        o_tready = 1'b0;
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h60 + k));
        chk("pp_full_data", m_data, 24'h606162);
        o_tready = 1'b1;
        step(1'b1, 8'h68);
        chk("pp_valid", m_valid, 1);
        chk("pp_addr", m_addr, 1);
        chk("pp_data", m_data, 24'h636465);
        chk("pp_ovf", m_ovf, 0);
        step(1'b0, 8'h00);
        chk("pp_addr2", m_addr, 2);
        chk("pp_data2", m_data, 24'h666768);
        step(1'b0, 8'h00);
        chk("pp_empty", m_valid, 0);

        // Backpressure with overflow.
        do_reset();
        sel = 0;
        o_tready = 1'b0;
        for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h40 + k));
        step(1'b0, 8'h00);
        chk("bp_valid", m_valid, 1);
        chk("bp_hold_data", m_data, 24'h404142);
        chk("bp_hold_addr", m_addr, 0);
        chk("bp_ovf", m_ovf, 1);
        o_tready = 1'b1;
        step(1'b0, 8'h00);
        chk("bp_pop1_valid", m_valid, 1);
        chk("bp_pop1_addr", m_addr, 1);
        chk("bp_pop1_data", m_data, 24'h434445);
        step(1'b0, 8'h00);
        chk("bp_drained", m_valid, 0);
        step(1'b1, 8'h50);
        step(1'b1, 8'h51);
        step(1'b1, 8'h52);
        chk("bp_next_valid", m_valid, 1);
        chk("bp_next_addr", m_addr, 3);
        chk("bp_next_data", m_data, 24'h505152);
        chk("bp_ovf_sticky", m_ovf, 1);

        // Reset mid-pixel while overflow is still set.
        step(1'b1, 8'hEE);
        step(1'b1, 8'hFF);
        do_reset();
        #1;
        chk("rmid_valid", m_valid, 0);
        chk("rmid_ovf", m_ovf, 0);
        chk("rmid_fd", m_fd, 0);
        chk("rmid_fcnt", m_fcnt, 0);
        step(1'b1, 8'h07);
        step(1'b1, 8'h08);
        step(1'b1, 8'h09);
        chk("rmid_pix_valid", m_valid, 1);
        chk("rmid_pix_data", m_data, 24'h070809);
        chk("rmid_pix_addr", m_addr, 0);
        chk("rmid_pix_ovf", m_ovf, 0);

`ifdef PACKER_HDR_SKIP_EN
        // Header skip at the start of every frame.
        do_reset();
        sel = 2;
        step(1'b1, 8'hAA);
        step(1'b1, 8'hBB);
        chk("hdr_skip_valid", m_valid, 0);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        chk("hdr_pix_valid", m_valid, 1);
        chk("hdr_pix_data", m_data, 24'h010203);
        chk("hdr_pix_addr", m_addr, 0);
        for (int p = 1; p < 8; p++) begin
            for (int b = 0; b < 3; b++) step(1'b1, 8'(16*p + b));
            chk($sformatf("hdr_p%0d_addr", p), m_addr, 32'(p));
        end
        chk("hdr_fd", m_fd, 1);
        step(1'b1, 8'hAA);
        step(1'b1, 8'hBB);
        chk("hdr2_skip_valid", m_valid, 0);
        step(1'b1, 8'h04);
        step(1'b1, 8'h05);
        step(1'b1, 8'h06);
        chk("hdr2_pix_data", m_data, 24'h040506);
        chk("hdr2_pix_addr", m_addr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_pixel_packer.md
# sd_pixel_packer

Packs the raw byte stream from `sd_spi_file_reader` (`outen`/`outbyte`) into multi-byte pixels with framebuffer addresses. Replaces the fixed 3-way byte steering and free-running byte address used in the first bring-up, and sits between the SD file reader and the BRAM framebuffer write port. Pixel width, frame geometry and end-of-frame policy are parametrised. Completed pixels leave through a 2-entry valid/ready buffer, and lost pixels are reported rather than silently dropped.

## Interface
Parameters:
- `BYTES_PER_PIXEL`, default 3: bytes per pixel, range 1..4.
- `FRAME_W`, default 640: pixels per line.
- `FRAME_H`, default 480: lines per frame.
- `ADDR_W`, default 19: pixel-address width; must satisfy 2^ADDR_W ≥ FRAME_W*FRAME_H.
- `LOOP`, default 1: 1 = wrap to the next frame; 0 = stop after one frame.
- `HDR_BYTES`, default 0: per-frame header length in bytes; used only with `PACKER_HDR_SKIP_EN`.

Ports:
- `clk` in 1: system clock (50 MHz domain).
- `reset` in 1: asynchronous active-high reset.
- `i_tvalid` in 1: byte strobe. Connects to `outen`. There is no backpressure.
- `i_tdata` in 8: byte value. Connects to `outbyte`.
- `o_tvalid` out 1: a pixel is available.
- `o_tready` in 1: the consumer accepts the pixel.
- `o_tdata` out 8*BYTES_PER_PIXEL: pixel data. The first received byte sits in the MSBs.
- `o_taddr` out ADDR_W: pixel index within the frame.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is completed.
- `frame_cnt` out 8: count of completed frames, wraps at 256.
- `overflow` out 1: sticky flag, set when a pixel is dropped.

## Operation
- State machine: HDR → PIX → DONE.
  - The reset state is HDR if `PACKER_HDR_SKIP_EN` is defined and HDR_BYTES > 0; otherwise PIX.
- HDR:
  - Each input byte increments `hdr_cnt`.
  - The byte that makes `hdr_cnt` equal HDR_BYTES is discarded, and the state moves to PIX.
- PIX:
  - Each byte shifts into the assembly register `asm = {asm, i_tdata}`, and `byte_cnt` increments.
  - On byte index BYTES_PER_PIXEL-1, the pixel completes:
    - `{asm, i_tdata}` is pushed with the current `pix_addr`.
    - `byte_cnt` is cleared.
    - `pix_addr` increments.
- End of frame: when the pixel completed is at `pix_addr` = FRAME_W*FRAME_H-1:
  - `pix_addr` is set to 0, `frame_done` pulses, and `frame_cnt` increments.
  - Next state is HDR, or PIX when there is no header; DONE if LOOP=0.
- DONE: input bytes are ignored. The state is left only by reset.
- Output buffer: 2-entry FIFO of {data, addr}.
  - `o_tvalid` = entry count ≠ 0.
  - Pop on `o_tvalid & o_tready`.
- Full buffer: if a pixel completes while the count is 2 and no pop happens in the same cycle:
  - The pixel is dropped and `overflow` is set.
  - `pix_addr`, `frame_done` and `frame_cnt` still advance, so frame geometry is kept.
- Push and pop in the same cycle with the count at 2: accepted, and the count stays 2.
- Arithmetic: all counters are unsigned and wrap modulo their width. `pix_addr` is explicitly reset at the frame end, never left to wrap.

## Timing
- Reset values:
  - `o_tvalid`=0, `o_tdata`=0, `o_taddr`=0, `frame_done`=0, `frame_cnt`=0, `overflow`=0.
  - Internal: `byte_cnt`=0, `pix_addr`=0, `hdr_cnt`=0.
- Latency: last byte of a pixel sampled at edge N → `o_tvalid`=1 with that pixel after edge N (visible in cycle N+1), provided the buffer was empty.
- `frame_done` is registered and asserted in cycle N+1, together with the final pixel's `o_tvalid`.
- `o_tdata`/`o_taddr` are held stable while `o_tvalid & ~o_tready`.
- Back-to-back bytes every cycle are supported. The sustained pixel rate is 1 per BYTES_PER_PIXEL cycles.
- Reset asserted mid-pixel or mid-frame: partial bytes are lost and the buffer empties immediately (asynchronous). After release, counting restarts at `pix_addr` 0.

## Configuration
- `PACKER_HDR_SKIP_EN`:
  - Defined: the HDR state, `hdr_cnt` and the HDR_BYTES skip are compiled in. The header is skipped at the start of every frame.
  - Undefined: HDR logic is absent and HDR_BYTES is ignored. Every byte is pixel data, and the reset state is PIX.

## Test plan
- Basic packing. BYTES_PER_PIXEL=3, FRAME 4×2, `o_tready`=1; bytes 0x11,0x22,0x33,0x44,0x55,0x66 → pixel 0x112233 at addr 0, then 0x445566 at addr 1, each `o_tvalid` one cycle after its third byte.
- Frame wrap. LOOP=1, stream 27 bytes → 8 pixels at addr 0..7, `frame_done` pulses once with pixel 7, `frame_cnt`=1. The 9th pixel appears at addr 0.
- One-shot. LOOP=0, stream 30 bytes → 8 pixels output, the last 6 bytes ignored, `frame_cnt`=1, state DONE.
- Backpressure and overflow. `o_tready`=0, stream 9 bytes → 2 pixels held (addr 0, 1), the third pixel is dropped and `overflow`=1. Raise `o_tready` → exactly addr 0, 1 are delivered. The next pixel is at addr 3.
- Header skip. With `PACKER_HDR_SKIP_EN`, HDR_BYTES=2, bytes 0xAA,0xBB,0x01,0x02,0x03 → single pixel 0x010203 at addr 0. After 8 pixels, the next 2 bytes are skipped again.
- Reset mid-pixel. Send 2 bytes, assert `reset` for 1 cycle, then send 0x07,0x08,0x09 → pixel 0x070809 at addr 0, and all flags are 0.
